// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared constants and types for the write-back arbiter slice.
//   ADDR_W     : register-file address width
//   DATA_W     : register-file data width
//   ZERO_REG   : hardwired-zero register; writes to it are accepted and dropped
//   wb_entry_t : one queued write, {addr, data}
//   prio_t     : round-robin priority holder (which requester wins a tie)
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Circular write queue of wb_entry_t, DEPTH entries (power of two, >= 2).
// Push and pop may happen on the same edge; pointers wrap modulo DEPTH.
// Optional feature macro: WB_SCOREBOARD_EN exposes per-entry valid/address
// so the parent can build a pending-register mask.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_push          : write i_push_entry at the tail this edge (never when full)
//   i_pop           : drop the head this edge (never when empty)
//   o_full, o_empty : occupancy flags (registered state)
//   o_count         : occupancy, $clog2(DEPTH)+1 bits
//   o_head          : entry at the head of the queue
//   o_entry_valid   : (WB_SCOREBOARD_EN) slot i holds a live entry
//   o_entry_addr    : (WB_SCOREBOARD_EN) address field of slot i
// -----------------------------------------------------------------------------
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_push,
  input  wb_entry_t                         i_push_entry,
  input  logic                              i_pop,
  output logic                              o_full,
  output logic                              o_empty,
  output logic [$clog2(DEPTH):0]            o_count,
  output wb_entry_t                         o_head
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [DEPTH-1:0]                  o_entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]      o_entry_addr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Storage array; contents need no reset because occupancy gates every use.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == {CW{1'b0}});
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

`ifdef WB_SCOREBOARD_EN
  logic [AW-1:0] w_offset;

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    w_offset      = {AW{1'b0}};
    o_entry_valid = {DEPTH{1'b0}};
    o_entry_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_offset         = AW'(i) - r_rd_ptr;
      o_entry_valid[i] = ({1'b0, w_offset} < r_count);
      o_entry_addr[i]  = r_mem[i].addr;
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Two-requester round-robin write-back arbiter feeding a register file through
// a DEPTH-entry queue (wb_fifo). One write accepted per cycle; writes to the
// hardwired-zero register are accepted and dropped. The queue head is popped
// into registered rf_* outputs whenever the queue is non-empty and stall is low.
// Optional feature macro: WB_SCOREBOARD_EN adds the 'pending' output.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   reqN_valid/addr/data     : write request from requester N (N = 0, 1)
//   reqN_ready               : request N accepted this cycle (combinational)
//   stall                    : hold the drain this cycle
//   rf_W, rf_DA, rf_D        : registered register-file write port
//   q_count                  : queue occupancy
//   pending                  : (WB_SCOREBOARD_EN) bit i = write to Ri in flight
// -----------------------------------------------------------------------------
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic                   req1_valid,
  output logic                   req0_ready,
  output logic                   req1_ready,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [DATA_W-1:0]      req0_data,
  input  logic [DATA_W-1:0]      req1_data,
  input  logic                   stall,
  output logic                   rf_W,
  output logic [ADDR_W-1:0]      rf_DA,
  output logic [DATA_W-1:0]      rf_D,
  output logic [$clog2(DEPTH):0] q_count
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [31:0]            pending
`endif
);

  prio_t             r_prio;
  logic              r_rf_w;
  logic [ADDR_W-1:0] r_rf_da;
  logic [DATA_W-1:0] r_rf_d;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_push;
  logic              w_pop;
  wb_entry_t         w_push_entry;
  logic              w_full;
  logic              w_empty;
  wb_entry_t         w_head;

`ifdef WB_SCOREBOARD_EN
  logic [DEPTH-1:0]             w_entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] w_entry_addr;
  logic [31:0]                  w_pending;
`endif

  // Grant selection. Ready looks only at registered fullness, so a pop on the
  // same edge never opens a slot early.
  always_comb begin
    w_grant0           = 1'b0;
    w_grant1           = 1'b0;
    w_push_entry.addr  = req0_addr;
    w_push_entry.data  = req0_data;
    if (!w_full) begin
      w_grant0 = req0_valid && (!req1_valid || (r_prio == PRIO_REQ0));
      w_grant1 = req1_valid && (!req0_valid || (r_prio == PRIO_REQ1));
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
    if (w_grant1) begin
      w_push_entry.addr = req1_addr;
      w_push_entry.data = req1_data;
    end else begin
      w_push_entry.addr = req0_addr;
      w_push_entry.data = req0_data;
    end
  end

  // Writes to the zero register complete the handshake but never enter the queue.
  assign w_push     = (w_grant0 || w_grant1) && (w_push_entry.addr != ZERO_REG);
  assign w_pop      = !w_empty && !stall;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Round-robin: after a transfer, the loser of that transfer gets priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= PRIO_REQ0;
    end else if (w_grant0) begin
      r_prio <= PRIO_REQ1;
    end else if (w_grant1) begin
      r_prio <= PRIO_REQ0;
    end else begin
      r_prio <= r_prio;
    end
  end

  // Register-file output stage; address and data hold when nothing is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_w  <= 1'b0;
      r_rf_da <= {ADDR_W{1'b0}};
      r_rf_d  <= {DATA_W{1'b0}};
    end else if (w_pop) begin
      r_rf_w  <= 1'b1;
      r_rf_da <= w_head.addr;
      r_rf_d  <= w_head.data;
    end else begin
      r_rf_w  <= 1'b0;
    end
  end

  assign rf_W  = r_rf_w;
  assign rf_DA = r_rf_da;
  assign rf_D  = r_rf_d;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (q_count),
    .o_head       (w_head)
`ifdef WB_SCOREBOARD_EN
    ,
    .o_entry_valid(w_entry_valid),
    .o_entry_addr (w_entry_addr)
`endif
  );

`ifdef WB_SCOREBOARD_EN
  // Pending mask: every queued destination plus the one being written now.
  always_comb begin
    w_pending = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pending = w_pending | (w_entry_valid[i] ? (32'd1 << w_entry_addr[i]) : 32'd0);
    end
    w_pending = w_pending | (r_rf_w ? (32'd1 << r_rf_da) : 32'd0);
    w_pending[ZERO_REG] = 1'b0;
  end

  assign pending = w_pending;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Scoreboard bench for wb_arbiter (DEPTH = 4). A reference model (queue of
// writes, priority bit) predicts ready/q_count/rf_W each cycle; every write
// the model drains is pushed to exp_q and a separate monitor pops and compares
// it when the DUT raises rf_W. Directed scenarios are followed by random
// traffic. With WB_SCOREBOARD_EN the pending output is also predicted.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        stall;
  logic        rf_W;
  logic [4:0]  rf_DA;
  logic [31:0] rf_D;
  logic [2:0]  q_count;
`ifdef WB_SCOREBOARD_EN
  logic [31:0] pending;
`endif

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_data(req0_data), .req1_data(req1_data),
    .stall(stall), .rf_W(rf_W), .rf_DA(rf_DA), .rf_D(rf_D),
    .q_count(q_count)
`ifdef WB_SCOREBOARD_EN
    , .pending(pending)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  ent_t mq[$];
  ent_t exp_q[$];
  bit   m_prio = 1'b0;
  bit   m_rfw = 1'b0;
  logic [4:0]  m_da = 5'd0;
  logic [31:0] m_d = 32'd0;
  logic [4:0]  mon_da = 5'd0;
  logic [31:0] mon_d = 32'd0;
  bit   got_r0, got_r1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef WB_SCOREBOARD_EN
  function automatic logic [31:0] pend_model();
    logic [31:0] p = 32'd0;
    foreach (mq[i]) p[mq[i].a] = 1'b1;
    if (m_rfw) p[m_da] = 1'b1;
    p[31] = 1'b0;
    return p;
  endfunction
`endif

  // One clock cycle: drive at negedge, check ready, update the model at the
  // posedge, then check registered state at the next negedge.
  task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      input bit st);
    bit   full, g0, g1;
    ent_t e;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    stall = st;
    #1;
    full = (mq.size() == DEPTH);
    g0 = v0 && (!v1 || m_prio == 1'b0) && !full;
    g1 = v1 && (!v0 || m_prio == 1'b1) && !full;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    got_r0 = req0_ready;
    got_r1 = req1_ready;
    @(posedge clk);
    m_rfw = 1'b0;
    if (mq.size() > 0 && !st) begin
      e = mq.pop_front();
      exp_q.push_back(e);
      m_rfw = 1'b1;
      m_da = e.a;
      m_d = e.d;
    end
    if (g0 || g1) begin
      e.a = g0 ? a0 : a1;
      e.d = g0 ? d0 : d1;
      if (e.a != 5'd31) mq.push_back(e);
      m_prio = g0;
    end
    @(negedge clk);
    chk("q_count", {29'd0, q_count}, mq.size());
    chk("rf_W", {31'd0, rf_W}, {31'd0, m_rfw});
`ifdef WB_SCOREBOARD_EN
    chk("pending", pending, pend_model());
`endif
  endtask

  task automatic idle(input int n, input bit st);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, st);
  endtask

  // Asynchronous reset pulse issued between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; stall = 1'b0;
    req0_addr = 5'd0; req1_addr = 5'd0; req0_data = 32'd0; req1_data = 32'd0;
    #1;
    chk("rst_q_count", {29'd0, q_count}, 32'd0);
    chk("rst_rf_W", {31'd0, rf_W}, 32'd0);
    chk("rst_rf_DA", {27'd0, rf_DA}, 32'd0);
    chk("rst_rf_D", rf_D, 32'd0);
`ifdef WB_SCOREBOARD_EN
    chk("rst_pending", pending, 32'd0);
`endif
    mq.delete(); exp_q.delete();
    m_prio = 1'b0; m_rfw = 1'b0; m_da = 5'd0; m_d = 32'd0;
    mon_da = 5'd0; mon_d = 32'd0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_rf_W", {31'd0, rf_W}, 32'd0);
    rst = 1'b0;
  endtask

  // Monitor: compares each issued write against the scoreboard queue, and
  // checks that address/data hold between writes.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (rf_W) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rf_write: unexpected write addr=%0d data=%h at %0t", rf_DA, rf_D, $time);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("rf_DA", {27'd0, rf_DA}, {27'd0, e.a});
          chk("rf_D", rf_D, e.d);
          mon_da = e.a;
          mon_d = e.d;
        end
      end else begin
        chk("rf_DA_hold", {27'd0, rf_DA}, {27'd0, mon_da});
        chk("rf_D_hold", rf_D, mon_d);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; stall = 1'b0;
    req0_addr = 5'd0; req1_addr = 5'd0; req0_data = 32'd0; req1_data = 32'd0;
    @(negedge clk);
    do_reset();

    // Single write latency: accepted in cycle N, written in cycle N+2 only.
    step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("lat_n1_rf_W", {31'd0, rf_W}, 32'd0);
    idle(1, 1'b0);
    chk("lat_n2_rf_W", {31'd0, rf_W}, 32'd1);
    chk("lat_n2_rf_DA", {27'd0, rf_DA}, 32'd3);
    chk("lat_n2_rf_D", rf_D, 32'hDEADBEEF);
    idle(1, 1'b0);
    chk("lat_n3_rf_W", {31'd0, rf_W}, 32'd0);

    // Both requesters contend under stall: grants alternate, queue fills.
    do_reset();
    begin
      logic [7:0] gseq = 8'd0;
      for (int i = 0; i < 4; i++) begin
        step(1'b1, 5'(i + 1), 32'h100 + i, 1'b1, 5'(i + 9), 32'h200 + i, 1'b1);
        gseq = {gseq[5:0], got_r0, got_r1};
      end
      chk("grant_sequence", {24'd0, gseq}, 32'h0000_0099);
    end
    chk("full_q_count", {29'd0, q_count}, 32'd4);
    step(1'b1, 5'd5, 32'h300, 1'b1, 5'd13, 32'h400, 1'b1);
    chk("full_r0_low", {31'd0, got_r0}, 32'd0);
    chk("full_r1_low", {31'd0, got_r1}, 32'd0);

    // Release stall: first pop cycle still full, ready returns the next cycle.
    step(1'b1, 5'd20, 32'h500, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("drain_first_ready", {31'd0, got_r0}, 32'd0);
    chk("drain_first_rf_W", {31'd0, rf_W}, 32'd1);
    chk("drain_first_DA", {27'd0, rf_DA}, 32'd1);
    step(1'b1, 5'd20, 32'h500, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("drain_ready_back", {31'd0, got_r0}, 32'd1);
    idle(6, 1'b0);

    // Write to R31: handshake completes, nothing queued, priority moves to 0.
    step(1'b1, 5'd2, 32'h600, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'h1234, 1'b0);
    chk("r31_ready", {31'd0, got_r1}, 32'd1);
    chk("r31_q_count", {29'd0, q_count}, 32'd0);
    idle(1, 1'b0);
    chk("r31_no_write", {31'd0, rf_W}, 32'd0);
    step(1'b1, 5'd4, 32'h700, 1'b1, 5'd6, 32'h701, 1'b1);
    chk("r31_prio0_win", {30'd0, got_r0, got_r1}, 32'd2);
    idle(3, 1'b0);

    // Reset with three entries queued: everything discarded.
    for (int i = 0; i < 3; i++) step(1'b1, 5'(10 + i), 32'hA00 + i, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("pre_rst_count", {29'd0, q_count}, 32'd3);
    do_reset();
    idle(5, 1'b0);

`ifdef WB_SCOREBOARD_EN
    // Pending tracking: R5 stays pending until its second write is issued.
    do_reset();
    step(1'b1, 5'd5, 32'h51, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, 5'd5, 32'h52, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, 5'd7, 32'h71, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("pend_5_7", pending & 32'h0000_00A0, 32'h0000_00A0);
    idle(1, 1'b0);
    chk("pend_5_after_first", {31'd0, pending[5]}, 32'd1);
    idle(1, 1'b0);
    chk("pend_5_during_second", {31'd0, pending[5]}, 32'd1);
    idle(1, 1'b0);
    chk("pend_5_cleared", {31'd0, pending[5]}, 32'd0);
    chk("pend_7_writing", {31'd0, pending[7]}, 32'd1);
    idle(2, 1'b0);
`endif

    // Random traffic with a small address set so same-address writes collide.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ra0, ra1;
      ra0 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), ra0, $urandom,
           1'($urandom_range(0, 1)), ra1, $urandom,
           ($urandom_range(0, 9) < 3));
    end

    idle(8, 1'b0);
    chk("drained_scoreboard", exp_q.size(), 32'd0);
    chk("drained_model", {29'd0, q_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
